// File: rtl/linear_interpolator.sv
// Linear interpolation co-processor: reads (t0,u0),(t1,u1) and t from the shared RAM, writes u back, pulses DONE.
// Build macro LINEAR_INTERPOLATOR_ROUND_EN selects round-half-up of the product instead of floor.
module linear_interpolator #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 13,
  parameter int FRAC_BITS     = 32,
  parameter int ADDR_T0       = 0,
  parameter int ADDR_T1       = 1,
  parameter int ADDR_U0       = 2,
  parameter int ADDR_U1       = 3,
  parameter int ADDR_T        = 4,
  parameter int ADDR_OUT      = 5
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ENABLE,
  output logic                     DONE,
  output logic                     ERROR,
  output logic [ADDRESS_WIDTH-1:0] RAM_ADD_RD1,
  output logic [ADDRESS_WIDTH-1:0] RAM_ADD_RD2,
  input  logic [DATA_WIDTH-1:0]    RAM_DATA_RD1,
  input  logic [DATA_WIDTH-1:0]    RAM_DATA_RD2,
  output logic [ADDRESS_WIDTH-1:0] RAM_ADD_WR,
  output logic [DATA_WIDTH-1:0]    RAM_DATA_WR,
  output logic                     RAM_ENABLE_WR
);

  localparam int NW = DATA_WIDTH + 1;
  localparam int RW = FRAC_BITS + 1;
  localparam int PW = NW + RW + 1;
  localparam int CW = $clog2(FRAC_BITS + 1) + 1;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_RD0   = 4'd1;
  localparam logic [3:0] S_RD1   = 4'd2;
  localparam logic [3:0] S_RD2   = 4'd3;
  localparam logic [3:0] S_SETUP = 4'd4;
  localparam logic [3:0] S_DIV   = 4'd5;
  localparam logic [3:0] S_MUL   = 4'd6;
  localparam logic [3:0] S_WR    = 4'd7;
  localparam logic [3:0] S_DN    = 4'd8;

  localparam logic [ADDRESS_WIDTH-1:0] A_T0  = ADDRESS_WIDTH'(ADDR_T0);
  localparam logic [ADDRESS_WIDTH-1:0] A_T1  = ADDRESS_WIDTH'(ADDR_T1);
  localparam logic [ADDRESS_WIDTH-1:0] A_U0  = ADDRESS_WIDTH'(ADDR_U0);
  localparam logic [ADDRESS_WIDTH-1:0] A_U1  = ADDRESS_WIDTH'(ADDR_U1);
  localparam logic [ADDRESS_WIDTH-1:0] A_T   = ADDRESS_WIDTH'(ADDR_T);
  localparam logic [ADDRESS_WIDTH-1:0] A_OUT = ADDRESS_WIDTH'(ADDR_OUT);

  localparam logic [RW-1:0] R_ONE    = {1'b1, {FRAC_BITS{1'b0}}};
  localparam logic [RW-1:0] R_ZERO   = '0;
  localparam logic [NW-1:0] ONE_N    = NW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAC_BITS);

  logic [3:0]            state_q, state_d;
  logic                  armed_q, armed_d;
  logic                  error_q, error_d;
  logic [DATA_WIDTH-1:0] t0_q, t0_d, t1_q, t1_d;
  logic [DATA_WIDTH-1:0] u0_q, u0_d, u1_q, u1_d;
  logic [DATA_WIDTH-1:0] u_q, u_d;
  logic [NW:0]           rem_q, rem_d;
  logic [NW-1:0]         dmag_q, dmag_d;
  logic [RW-1:0]         quo_q, quo_d;
  logic                  force_q, force_d;
  logic [RW-1:0]         force_r_q, force_r_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  // Interval offsets; t arrives on read port 1 during SETUP.
  logic signed [NW-1:0] n_s, d_s;
  logic [NW-1:0]        n_mag, d_mag;
  assign n_s   = {RAM_DATA_RD1[DATA_WIDTH-1], RAM_DATA_RD1} - {t0_q[DATA_WIDTH-1], t0_q};
  assign d_s   = {t1_q[DATA_WIDTH-1], t1_q} - {t0_q[DATA_WIDTH-1], t0_q};
  assign n_mag = n_s[NW-1] ? (~n_s + ONE_N) : n_s;
  assign d_mag = d_s[NW-1] ? (~d_s + ONE_N) : d_s;

  // One restoring-division step: the remainder stays below 2*|d|.
  logic          div_ge;
  logic [NW:0]   rem_sub, rem_step;
  assign div_ge   = rem_q >= {1'b0, dmag_q};
  assign rem_sub  = div_ge ? (rem_q - {1'b0, dmag_q}) : rem_q;
  assign rem_step = {rem_sub[NW-1:0], 1'b0};

  logic [RW-1:0]         r_sel;
  logic signed [NW-1:0]  diff_s;
  logic signed [PW-1:0]  diff_x, r_x, prod, prod_r;
  logic [DATA_WIDTH-1:0] u_next;
  assign r_sel  = force_q ? force_r_q : quo_q;
  assign diff_s = {u1_q[DATA_WIDTH-1], u1_q} - {u0_q[DATA_WIDTH-1], u0_q};
  assign diff_x = {{(PW-NW){diff_s[NW-1]}}, diff_s};
  assign r_x    = {{(PW-RW){1'b0}}, r_sel};
  assign prod   = diff_x * r_x;
`ifdef LINEAR_INTERPOLATOR_ROUND_EN
  localparam logic signed [PW-1:0] HALF = {{(PW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
  assign prod_r = prod + HALF;
`else
  assign prod_r = prod;
`endif
  // Slicing above FRAC_BITS is the floor shift; only the low word of u0 + p is kept.
  assign u_next = u0_q + prod_r[FRAC_BITS +: DATA_WIDTH];

  logic unused_bits;
  assign unused_bits = ^{rem_sub[NW], prod_r[FRAC_BITS-1:0], prod_r[PW-1:FRAC_BITS+DATA_WIDTH]};

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    error_d   = error_q;
    t0_d      = t0_q;
    t1_d      = t1_q;
    u0_d      = u0_q;
    u1_d      = u1_q;
    u_d       = u_q;
    rem_d     = rem_q;
    dmag_d    = dmag_q;
    quo_d     = quo_q;
    force_d   = force_q;
    force_r_d = force_r_q;
    cnt_d     = cnt_q;
    if (!ENABLE) armed_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (ENABLE && armed_q) begin
          state_d = S_RD0;
          error_d = 1'b0;
          armed_d = 1'b0;
        end
      end
      S_RD0: state_d = S_RD1;
      S_RD1: begin
        t0_d    = RAM_DATA_RD1;
        t1_d    = RAM_DATA_RD2;
        state_d = S_RD2;
      end
      S_RD2: begin
        u0_d    = RAM_DATA_RD1;
        u1_d    = RAM_DATA_RD2;
        state_d = S_SETUP;
      end
      S_SETUP: begin
        rem_d  = {1'b0, n_mag};
        dmag_d = d_mag;
        quo_d  = '0;
        cnt_d  = '0;
        // Degenerate or out-of-range cases bypass the quotient but keep the divider running.
        if (d_s == '0 || (n_s != '0 && n_s[NW-1] != d_s[NW-1])) begin
          force_d   = 1'b1;
          force_r_d = R_ZERO;
          error_d   = 1'b1;
        end else if (n_mag >= d_mag) begin
          force_d   = 1'b1;
          force_r_d = R_ONE;
          error_d   = n_mag > d_mag;
        end else begin
          force_d   = 1'b0;
          force_r_d = R_ZERO;
        end
        state_d = S_DIV;
      end
      S_DIV: begin
        rem_d = rem_step;
        quo_d = {quo_q[RW-2:0], div_ge};
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = S_MUL;
      end
      S_MUL: begin
        u_d     = u_next;
        state_d = S_WR;
      end
      S_WR:    state_d = S_DN;
      S_DN:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      armed_q   <= 1'b1;
      error_q   <= 1'b0;
      t0_q      <= '0;
      t1_q      <= '0;
      u0_q      <= '0;
      u1_q      <= '0;
      u_q       <= '0;
      rem_q     <= '0;
      dmag_q    <= '0;
      quo_q     <= '0;
      force_q   <= 1'b0;
      force_r_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      error_q   <= error_d;
      t0_q      <= t0_d;
      t1_q      <= t1_d;
      u0_q      <= u0_d;
      u1_q      <= u1_d;
      u_q       <= u_d;
      rem_q     <= rem_d;
      dmag_q    <= dmag_d;
      quo_q     <= quo_d;
      force_q   <= force_d;
      force_r_q <= force_r_d;
      cnt_q     <= cnt_d;
    end
  end

  // RAM addresses are decoded from the state so the read lands one cycle later.
  always_comb begin
    RAM_ADD_RD1 = '0;
    RAM_ADD_RD2 = '0;
    case (state_q)
      S_RD0: begin
        RAM_ADD_RD1 = A_T0;
        RAM_ADD_RD2 = A_T1;
      end
      S_RD1: begin
        RAM_ADD_RD1 = A_U0;
        RAM_ADD_RD2 = A_U1;
      end
      S_RD2:   RAM_ADD_RD1 = A_T;
      default: ;
    endcase
  end

  assign RAM_ENABLE_WR = (state_q == S_WR);
  assign RAM_ADD_WR    = (state_q == S_WR) ? A_OUT : '0;
  assign RAM_DATA_WR   = u_q;
  assign DONE          = (state_q == S_DN);
  assign ERROR         = error_q;

endmodule

// File: tb/tb_linear_interpolator.sv
// Bench for linear_interpolator: RAM model, protocol/arithmetic reference model and directed vectors.
// Build with LINEAR_INTERPOLATOR_ROUND_EN defined to check the rounding variant.
module tb_linear_interpolator;
  localparam int DW  = 64;
  localparam int AW  = 13;
  localparam int F   = 32;
  localparam int LAT = F + 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          done, error, we;
  logic [AW-1:0] add_rd1, add_rd2, add_wr;
  logic [DW-1:0] rd1, rd2, data_wr;

  linear_interpolator dut (
    .CLK(clk), .RST(rst), .ENABLE(enable), .DONE(done), .ERROR(error),
    .RAM_ADD_RD1(add_rd1), .RAM_ADD_RD2(add_rd2),
    .RAM_DATA_RD1(rd1), .RAM_DATA_RD2(rd2),
    .RAM_ADD_WR(add_wr), .RAM_DATA_WR(data_wr), .RAM_ENABLE_WR(we)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            wr_count = 0;
  int            done_count = 0;
  logic [DW-1:0] last_wr = '0;

  always @(posedge clk) begin
    rd1 <= mem[add_rd1];
    rd2 <= mem[add_rd2];
    if (we) begin
      wr_count <= wr_count + 1;
      last_wr  <= data_wr;
    end
    if (done) done_count <= done_count + 1;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] fx(input int i);
    fx = {32'(i), 32'h0};
  endfunction

  // Reference: u = u0 + floor((u1-u0)*r), r = |t-t0|/|t1-t0| clamped to [0,1]; returns {error,u}.
  function automatic logic [64:0] model(input logic signed [63:0] t0, t1, u0, u1, t);
    logic signed [64:0]  n, d;
    logic [64:0]         an, ad;
    logic [127:0]        r;
    logic                err;
    logic signed [131:0] diff, rs, p, res;
    n  = t - t0;
    d  = t1 - t0;
    an = n[64] ? -n : n;
    ad = d[64] ? -d : d;
    if (d == 0) begin
      r = '0; err = 1'b1;
    end else if (n != 0 && (n[64] != d[64])) begin
      r = '0; err = 1'b1;
    end else if (an >= ad) begin
      r = 128'd1 << F; err = (an > ad);
    end else begin
      r = ({63'b0, an} << F) / {63'b0, ad}; err = 1'b0;
    end
    diff = u1 - u0;
    rs   = $signed({4'b0, r});
    p    = diff * rs;
`ifdef LINEAR_INTERPOLATOR_ROUND_EN
    p = p + (132'sd1 <<< (F - 1));
`endif
    res   = u0 + (p >>> F);
    model = {err, res[63:0]};
  endfunction

  // Protocol tracker: when an operation starts and what it must produce.
  int          cyc = 0;
  int          s_cyc = 0;
  logic        busy = 1'b0;
  logic        armed = 1'b1;
  logic        have_result = 1'b0;
  logic [64:0] exp_pair = '0;
  logic        mon_on = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      busy        <= 1'b0;
      armed       <= 1'b1;
      have_result <= 1'b0;
    end else begin
      if (!enable) armed <= 1'b1;
      if (!busy && armed && enable) begin
        busy        <= 1'b1;
        armed       <= 1'b0;
        s_cyc       <= cyc + 1;
        exp_pair    <= model(mem[0], mem[1], mem[2], mem[3], mem[4]);
        have_result <= 1'b1;
      end else if (busy && (cyc + 1 == s_cyc + LAT)) begin
        busy <= 1'b0;
      end
    end
  end

  initial forever begin
    logic exp_we, exp_done;
    @(negedge clk);
    if (mon_on) begin
      exp_we   = busy && (cyc == s_cyc + LAT - 2);
      exp_done = busy && (cyc == s_cyc + LAT - 1);
      check("wr_en", 64'(we), 64'(exp_we));
      check("done", 64'(done), 64'(exp_done));
      if (exp_we) begin
        check("wr_addr", 64'(add_wr), 64'd5);
        check("wr_data", data_wr, exp_pair[63:0]);
      end
      if (exp_done || !busy)
        check("error", 64'(error), 64'(have_result ? exp_pair[64] : 1'b0));
    end
  end

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (done !== 1'b1 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("done_seen", 64'(done), 64'd1);
  endtask

  task automatic load(input logic [63:0] t0, t1, u0, u1, t);
    mem[0] = t0; mem[1] = t1; mem[2] = u0; mem[3] = u1; mem[4] = t;
  endtask

  task automatic run_op(input string name, input logic [63:0] t0, t1, u0, u1, t,
                        input logic [63:0] lit_u, input logic lit_err);
    int wr0, st;
    load(t0, t1, u0, u1, t);
    @(negedge clk);
    wr0    = wr_count;
    enable = 1'b1;
    st     = cyc + 1;
    @(negedge clk);
    enable = 1'b0;
    wait_done(LAT + 20);
    check({name, "_latency"}, 64'(cyc - st), 64'(LAT - 1));
    check({name, "_writes"}, 64'(wr_count), 64'(wr0 + 1));
    check({name, "_data"}, last_wr, lit_u);
    check({name, "_err"}, 64'(error), 64'(lit_err));
    check({name, "_model"}, exp_pair[63:0], lit_u);
    $display("op %s: u=%h error=%0b latency=%0d", name, last_wr, error, cyc - st + 1);
    @(negedge clk);
  endtask

  initial begin
    int wr0, d0, st;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_we", 64'(we), 64'd0);
    check("rst_rd1", 64'(add_rd1), 64'd0);
    check("rst_rd2", 64'(add_rd2), 64'd0);
    check("rst_wa", 64'(add_wr), 64'd0);
    check("rst_wd", data_wr, 64'd0);
    rst    = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);

    run_op("mid", fx(1), fx(3), fx(10), fx(20), fx(2), 64'h0000000F_00000000, 1'b0);
    run_op("neg_slope", fx(0), fx(4), fx(20), fx(-4), fx(1), 64'h0000000E_00000000, 1'b0);
    run_op("clamp_hi", fx(1), fx(3), fx(10), fx(20), fx(5), fx(20), 1'b1);
    run_op("at_t0", fx(1), fx(3), fx(10), fx(20), fx(1), fx(10), 1'b0);
    run_op("zero_int", fx(2), fx(2), fx(7), fx(9), fx(5), fx(7), 1'b1);
    run_op("before_t0", fx(2), fx(4), fx(6), fx(9), fx(1), fx(6), 1'b1);
    run_op("rev_int", fx(4), fx(0), fx(0), fx(8), fx(3), fx(2), 1'b0);
    run_op("third", fx(0), fx(3), fx(0), fx(1), fx(1), 64'h00000000_55555555, 1'b0);
`ifdef LINEAR_INTERPOLATOR_ROUND_EN
    run_op("half_lsb", fx(0), fx(2), 64'd0, 64'd1, fx(1), 64'd1, 1'b0);
`else
    run_op("half_lsb", fx(0), fx(2), 64'd0, 64'd1, fx(1), 64'd0, 1'b0);
`endif

    // ENABLE held high: exactly one operation until it is dropped.
    load(fx(1), fx(3), fx(10), fx(20), fx(2));
    @(negedge clk);
    wr0    = wr_count;
    d0     = done_count;
    enable = 1'b1;
    repeat (100) @(negedge clk);
    check("hold_writes", 64'(wr_count), 64'(wr0 + 1));
    check("hold_dones", 64'(done_count), 64'(d0 + 1));
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    wait_done(LAT + 20);
    enable = 1'b0;
    check("rearm_writes", 64'(wr_count), 64'(wr0 + 2));
    check("rearm_data", last_wr, 64'h0000000F_00000000);
    $display("op hold_rearm: writes=%0d dones=%0d", wr_count - wr0, done_count - d0 + 1);
    @(negedge clk);

    // Reset at cycle 20 of an operation.
    load(fx(0), fx(4), fx(20), fx(-4), fx(1));
    @(negedge clk);
    wr0    = wr_count;
    d0     = done_count;
    enable = 1'b1;
    st     = cyc + 1;
    @(negedge clk);
    enable = 1'b0;
    while (cyc < st + 19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("abort_writes", 64'(wr_count), 64'(wr0));
    check("abort_dones", 64'(done_count), 64'(d0));
    $display("op abort: writes=%0d dones=%0d", wr_count - wr0, done_count - d0);
    run_op("after_abort", fx(0), fx(4), fx(20), fx(-4), fx(1), 64'h0000000E_00000000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "bench timeout");
  end
endmodule
